// File: rtl/pwm_capture.sv
// pwm_capture: measures period, per-class phase durations, shoot-through and timeout of a
// complementary PWM gate pair, reporting each completed pwm_in1 period.
module pwm_capture #(
  parameter logic [10:0] TIMEOUT = 11'd2047
) (
  input  logic        clock_in,
  input  logic        reset,
  input  logic        enable,
  input  logic        pwm_in1,
  input  logic        pwm_in2,
  output logic [10:0] period_count,
  output logic [10:0] high1_count,
  output logic [10:0] high2_count,
  output logic [10:0] dead_count,
  output logic [10:0] overlap_count,
  output logic        meas_valid,
  output logic        shoot_through,
  output logic        timeout
);
  typedef enum logic [1:0] {IDLE, WAIT_SYNC, MEASURE} state_t;
  state_t      state_q, state_d;
  logic [1:0]  sync1_q, sync2_q;
  logic        s1_prev_q;
  logic [10:0] per_q, per_d, h1_q, h1_d, h2_q, h2_d, dead_q, dead_d, ov_q, ov_d;
  logic [10:0] period_q, period_d, high1_q, high1_d, high2_q, high2_d;
  logic [10:0] dead_out_q, dead_out_d, ovl_q, ovl_d;
  logic        meas_valid_q, meas_valid_d, shoot_q, shoot_d, timeout_q, timeout_d;
  logic        s1, s2, rise, c_h1, c_h2, c_dead, c_ov;
  always_comb begin
    s1     = sync1_q[1];
    s2     = sync2_q[1];
    rise   = s1 & ~s1_prev_q;
    c_h1   = s1 & ~s2;
    c_h2   = ~s1 & s2;
    c_dead = ~s1 & ~s2;
    c_ov   = s1 & s2;
    state_d      = state_q;
    per_d        = per_q;
    h1_d         = h1_q;
    h2_d         = h2_q;
    dead_d       = dead_q;
    ov_d         = ov_q;
    period_d     = period_q;
    high1_d      = high1_q;
    high2_d      = high2_q;
    dead_out_d   = dead_out_q;
    ovl_d        = ovl_q;
    meas_valid_d = 1'b0;
    timeout_d    = timeout_q;
    shoot_d      = shoot_q | ((state_q != IDLE) & c_ov);
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = WAIT_SYNC;
          per_d   = '0;
          h1_d    = '0;
          h2_d    = '0;
          dead_d  = '0;
          ov_d    = '0;
        end
        WAIT_SYNC: begin
          if (rise) begin
            state_d = MEASURE;
            per_d   = 11'd1;
            h1_d    = {10'd0, c_h1};
            h2_d    = {10'd0, c_h2};
            dead_d  = {10'd0, c_dead};
            ov_d    = {10'd0, c_ov};
          end
        end
        MEASURE: begin
          // A rise coinciding with the timeout boundary still completes the period.
          if (rise) begin
            period_d     = per_q;
            high1_d      = h1_q;
            high2_d      = h2_q;
            dead_out_d   = dead_q;
            ovl_d        = ov_q;
            meas_valid_d = 1'b1;
            timeout_d    = 1'b0;
            per_d        = 11'd1;
            h1_d         = {10'd0, c_h1};
            h2_d         = {10'd0, c_h2};
            dead_d       = {10'd0, c_dead};
            ov_d         = {10'd0, c_ov};
          end else if (per_q == TIMEOUT) begin
            state_d   = WAIT_SYNC;
            timeout_d = 1'b1;
            per_d     = '0;
            h1_d      = '0;
            h2_d      = '0;
            dead_d    = '0;
            ov_d      = '0;
          end else begin
            per_d  = per_q + 11'd1;
            h1_d   = h1_q + {10'd0, c_h1};
            h2_d   = h2_q + {10'd0, c_h2};
            dead_d = dead_q + {10'd0, c_dead};
            ov_d   = ov_q + {10'd0, c_ov};
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      sync1_q      <= '0;
      sync2_q      <= '0;
      s1_prev_q    <= 1'b0;
      per_q        <= '0;
      h1_q         <= '0;
      h2_q         <= '0;
      dead_q       <= '0;
      ov_q         <= '0;
      period_q     <= '0;
      high1_q      <= '0;
      high2_q      <= '0;
      dead_out_q   <= '0;
      ovl_q        <= '0;
      meas_valid_q <= 1'b0;
      shoot_q      <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= {sync1_q[0], pwm_in1};
      sync2_q      <= {sync2_q[0], pwm_in2};
      s1_prev_q    <= s1;
      per_q        <= per_d;
      h1_q         <= h1_d;
      h2_q         <= h2_d;
      dead_q       <= dead_d;
      ov_q         <= ov_d;
      period_q     <= period_d;
      high1_q      <= high1_d;
      high2_q      <= high2_d;
      dead_out_q   <= dead_out_d;
      ovl_q        <= ovl_d;
      meas_valid_q <= meas_valid_d;
      shoot_q      <= shoot_d;
      timeout_q    <= timeout_d;
    end
  end
  assign period_count  = period_q;
  assign high1_count   = high1_q;
  assign high2_count   = high2_q;
  assign dead_count    = dead_out_q;
  assign overlap_count = ovl_q;
  assign meas_valid    = meas_valid_q;
  assign shoot_through = shoot_q;
  assign timeout       = timeout_q;
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed scenario tasks for pwm_capture with TIMEOUT=300.
module tb_pwm_capture;
  logic        clk = 1'b0, rst, enable, pwm_in1, pwm_in2;
  logic [10:0] period_count, high1_count, high2_count, dead_count, overlap_count;
  logic        meas_valid, shoot_through, timeout;
  int total = 0, bad = 0, cyc = 0, mv_cnt = 0, mv_cyc = 0, mv_prev = 0, rise_cyc = 0, m0;
  pwm_capture #(.TIMEOUT(11'd300)) dut (
    .clock_in(clk), .reset(rst), .enable(enable), .pwm_in1(pwm_in1), .pwm_in2(pwm_in2),
    .period_count(period_count), .high1_count(high1_count), .high2_count(high2_count),
    .dead_count(dead_count), .overlap_count(overlap_count), .meas_valid(meas_valid),
    .shoot_through(shoot_through), .timeout(timeout)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (meas_valid === 1'b1) begin
    mv_prev = mv_cyc;
    mv_cyc  = cyc;
    mv_cnt++;
  end
  task automatic seg(input logic v1, input logic v2, input int n);
    for (int i = 0; i < n; i++) begin
      if (v1 && !pwm_in1) rise_cyc = cyc;
      pwm_in1 = v1;
      pwm_in2 = v2;
      @(posedge clk); #1;
    end
  endtask
  task automatic comp_period();
    seg(1, 0, 100); seg(0, 0, 10); seg(0, 1, 80); seg(0, 0, 10);
  endtask
  task automatic test_reset();
    rst = 1; enable = 0; pwm_in1 = 0; pwm_in2 = 0;
    #1;
    total++;
    if ({period_count, high1_count, high2_count, dead_count, overlap_count, meas_valid, shoot_through, timeout} !== 58'd0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", {period_count, high1_count, high2_count, dead_count, overlap_count, meas_valid, shoot_through, timeout});
    end
    @(posedge clk); #1; rst = 0;
  endtask
  task automatic test_complementary();
    enable = 1; seg(0, 0, 4);
    m0 = mv_cnt;
    repeat (3) comp_period();
    seg(1, 0, 5);
    total++; if (mv_cnt - m0 != 3) begin bad++; $display("FAIL comp_meas_count got=%0d want=3", mv_cnt - m0); end
    total++; if (period_count !== 11'd200) begin bad++; $display("FAIL comp_period got=%0d want=200", period_count); end
    total++; if (high1_count !== 11'd100) begin bad++; $display("FAIL comp_high1 got=%0d want=100", high1_count); end
    total++; if (high2_count !== 11'd80) begin bad++; $display("FAIL comp_high2 got=%0d want=80", high2_count); end
    total++; if (dead_count !== 11'd20) begin bad++; $display("FAIL comp_dead got=%0d want=20", dead_count); end
    total++; if (overlap_count !== 11'd0) begin bad++; $display("FAIL comp_overlap got=%0d want=0", overlap_count); end
    total++; if (mv_cyc - rise_cyc != 3) begin bad++; $display("FAIL comp_latency got=%0d want=3", mv_cyc - rise_cyc); end
    total++; if (mv_cyc - mv_prev != 200) begin bad++; $display("FAIL comp_spacing got=%0d want=200", mv_cyc - mv_prev); end
    total++; if ({shoot_through, timeout} !== 2'b00) begin bad++; $display("FAIL comp_flags got=%b want=00", {shoot_through, timeout}); end
    seg(0, 0, 5);
  endtask
  task automatic test_overlap();
    repeat (2) begin seg(1, 0, 95); seg(1, 1, 5); seg(0, 1, 75); seg(0, 0, 25); end
    seg(1, 0, 5);
    total++; if (overlap_count !== 11'd5) begin bad++; $display("FAIL ovl_overlap got=%0d want=5", overlap_count); end
    total++; if (high1_count !== 11'd95) begin bad++; $display("FAIL ovl_high1 got=%0d want=95", high1_count); end
    total++; if (high2_count !== 11'd75) begin bad++; $display("FAIL ovl_high2 got=%0d want=75", high2_count); end
    total++; if (dead_count !== 11'd25) begin bad++; $display("FAIL ovl_dead got=%0d want=25", dead_count); end
    total++; if (period_count !== 11'd200) begin bad++; $display("FAIL ovl_period got=%0d want=200", period_count); end
    total++; if (shoot_through !== 1'b1) begin bad++; $display("FAIL ovl_shoot got=%b want=1", shoot_through); end
    seg(0, 0, 5);
    repeat (2) comp_period();
    seg(1, 0, 5);
    total++; if (overlap_count !== 11'd0) begin bad++; $display("FAIL ovl_fixed_overlap got=%0d want=0", overlap_count); end
    total++; if (shoot_through !== 1'b1) begin bad++; $display("FAIL ovl_sticky got=%b want=1", shoot_through); end
    seg(0, 0, 5);
    rst = 1; #1;
    total++; if (shoot_through !== 1'b0) begin bad++; $display("FAIL ovl_reset_clear got=%b want=0", shoot_through); end
    @(posedge clk); #1; rst = 0;
  endtask
  task automatic test_timeout();
    seg(0, 0, 4);
    seg(1, 0, 50); seg(0, 0, 50);
    seg(1, 0, 50); seg(0, 0, 252);
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL to_early got=%b want=0", timeout); end
    seg(0, 0, 1);
    total++; if (timeout !== 1'b1) begin bad++; $display("FAIL to_set got=%b want=1", timeout); end
    total++; if (period_count !== 11'd100) begin bad++; $display("FAIL to_hold_period got=%0d want=100", period_count); end
    m0 = mv_cnt;
    seg(0, 0, 5); seg(1, 0, 60); seg(0, 0, 60);
    total++; if (mv_cnt != m0 || timeout !== 1'b1) begin bad++; $display("FAIL to_first_rise got=%0d/%b want=%0d/1", mv_cnt, timeout, m0); end
    seg(1, 0, 5);
    total++; if (period_count !== 11'd120) begin bad++; $display("FAIL to_recover_period got=%0d want=120", period_count); end
    total++; if (timeout !== 1'b0 || mv_cnt != m0 + 1) begin bad++; $display("FAIL to_recover got=%b/%0d want=0/%0d", timeout, mv_cnt, m0 + 1); end
    seg(0, 0, 5);
  endtask
  task automatic test_exact_timeout();
    seg(1, 0, 150); seg(0, 0, 150); seg(1, 0, 5);
    total++; if (period_count !== 11'd300) begin bad++; $display("FAIL exact_period got=%0d want=300", period_count); end
    total++; if (high1_count !== 11'd150 || dead_count !== 11'd150) begin bad++; $display("FAIL exact_classes got=%0d/%0d want=150/150", high1_count, dead_count); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL exact_timeout got=%b want=0", timeout); end
    seg(0, 0, 5);
  endtask
  task automatic test_enable_drop();
    seg(1, 0, 40);
    total++; if (period_count !== 11'd10) begin bad++; $display("FAIL drop_pre_period got=%0d want=10", period_count); end
    m0 = mv_cnt;
    enable = 0; seg(0, 0, 10);
    enable = 1; seg(0, 0, 5);
    seg(1, 0, 30); seg(0, 0, 30);
    total++; if (mv_cnt != m0 || period_count !== 11'd10) begin bad++; $display("FAIL drop_hold got=%0d/%0d want=%0d/10", mv_cnt, period_count, m0); end
    seg(1, 0, 5);
    total++; if (mv_cnt != m0 + 1 || period_count !== 11'd60) begin bad++; $display("FAIL drop_resume got=%0d/%0d want=%0d/60", mv_cnt, period_count, m0 + 1); end
    seg(0, 0, 5);
  endtask
  task automatic test_reset_mid();
    seg(1, 0, 20);
    #2 rst = 1;
    #1;
    total++;
    if ({period_count, high1_count, high2_count, dead_count, overlap_count, meas_valid, shoot_through, timeout} !== 58'd0) begin
      bad++; $display("FAIL midreset_outputs got=%h want=0", {period_count, high1_count, high2_count, dead_count, overlap_count, meas_valid, shoot_through, timeout});
    end
    @(posedge clk); #1; rst = 0;
    seg(0, 0, 3);
    m0 = mv_cnt;
    seg(1, 0, 50); seg(0, 0, 50);
    total++; if (mv_cnt != m0) begin bad++; $display("FAIL midreset_first_rise got=%0d want=%0d", mv_cnt, m0); end
    seg(1, 0, 5);
    total++; if (mv_cnt != m0 + 1 || period_count !== 11'd100) begin bad++; $display("FAIL midreset_restart got=%0d/%0d want=%0d/100", mv_cnt, period_count, m0 + 1); end
  endtask
  initial begin
    test_reset();
    test_complementary();
    test_overlap();
    test_timeout();
    test_exact_timeout();
    test_enable_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
